// File: rtl/dm_responder_if.sv
// Load/store request and response bundle between the mips core (master) and
// its data-memory responder (slave).
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, single-cycle response.
// Define DM_TRACE_EN to print a line for every committed store.
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              we_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [3:0]        be_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       pc_reg;
  logic              err_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              accept_err;
  logic              enter_resp;
  logic              commit;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_zero;
  logic [31:0]       merged_word;

  assign accept     = bus.req_valid && (state_reg == IDLE);
  assign accept_err = (bus.req_addr[31:ADDR_W+2] != '0) || (bus.req_we && (bus.req_be == 4'b0));
  assign commit     = (state_reg == RESP) && we_reg && !err_reg;

  // With no wait states RESP is entered on the acceptance edge, so read the live request.
  assign rd_idx  = (state_reg == IDLE) ? bus.req_addr[ADDR_W+1:2] : idx_reg;
  assign rd_zero = (state_reg == IDLE) ? (bus.req_we || accept_err) : (we_reg || err_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next = WAIT_INIT;
          if (WAIT_INIT == 8'd0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = 8'(cnt_reg - 8'd1);
        if (cnt_reg <= 8'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      pc_reg    <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= bus.req_we;
        idx_reg   <= bus.req_addr[ADDR_W+1:2];
        be_reg    <= bus.req_be;
        wdata_reg <= bus.req_wdata;
        pc_reg    <= bus.req_pc;
        err_reg   <= accept_err;
      end
      if (enter_resp) begin
        rdata_reg <= rd_zero ? 32'h0 : mem[rd_idx];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : mem[idx_reg][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[idx_reg] <= merged_word;
    end
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = (state_reg == RESP) && err_reg;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[1:0];

`ifdef DM_TRACE_EN
  logic [31:0] trace_addr;
  assign trace_addr = {{(30-ADDR_W){1'b0}}, idx_reg, 2'b00};

  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      $display("%d@%h: *%h <= %h", $time, pc_reg, trace_addr, merged_word);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_reg;
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: one instance with no wait states, one with three.
module tb_dm_responder;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dm_responder_if bus0();
  dm_responder_if bus3();

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.rsp_valid === 1'b1) begin
      exp_t e;
      if (q0.size() == 0) begin
        chk("rsp0_unexpected", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("rsp0_rdata", bus0.rsp_rdata, e.rdata);
        chk("rsp0_err", {31'b0, bus0.rsp_err}, {31'b0, e.err});
      end
      $display("t=%0t dut0 rsp rdata=%h err=%b", $time, bus0.rsp_rdata, bus0.rsp_err);
    end
  end

  always @(negedge clk) begin
    if (bus3.rsp_valid === 1'b1) begin
      exp_t e;
      if (q3.size() == 0) begin
        chk("rsp3_unexpected", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        chk("rsp3_rdata", bus3.rsp_rdata, e.rdata);
        chk("rsp3_err", {31'b0, bus3.rsp_err}, {31'b0, e.err});
      end
      $display("t=%0t dut3 rsp rdata=%h err=%b", $time, bus3.rsp_rdata, bus3.rsp_err);
    end
  end

  task automatic drive(input int sel, input logic v, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (sel == 0) begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr;
      bus0.req_be = be; bus0.req_wdata = wd; bus0.req_pc = 32'h0040_0000 | addr;
    end else begin
      bus3.req_valid = v; bus3.req_we = we; bus3.req_addr = addr;
      bus3.req_be = be; bus3.req_wdata = wd; bus3.req_pc = 32'h0040_0000 | addr;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.req_ready : bus3.req_ready;
  endfunction

  function automatic logic get_rvalid(input int sel);
    return (sel == 0) ? bus0.rsp_valid : bus3.rsp_valid;
  endfunction

  // Called and returns at a falling edge; checks latency and the ready/valid shape.
  task automatic xact(input int sel, input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee,
                      input bit hold, input string name);
    int   n;
    int   lat;
    exp_t e;
    lat = (sel == 0) ? 1 : 4;
    n = 0;
    while (!get_ready(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!get_ready(sel)) begin
      chk({name, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    drive(sel, 1'b1, we, addr, be, wd);
    e.rdata = er;
    e.err   = ee;
    if (sel == 0) q0.push_back(e); else q3.push_back(e);
    @(negedge clk);
    n = 1;
    if (!hold) drive(sel, 1'b0, we, addr, be, wd);
    while (!get_rvalid(sel) && n < 50) begin
      chk({name, "_ready_low"}, {31'b0, get_ready(sel)}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_ready_in_resp"}, {31'b0, get_ready(sel)}, 32'd0);
    drive(sel, 1'b0, we, addr, be, wd);
    @(negedge clk);
    chk({name, "_rsp_one_cycle"}, {31'b0, get_rvalid(sel)}, 32'd0);
    chk({name, "_ready_back"}, {31'b0, get_ready(sel)}, 32'd1);
    $display("t=%0t %s sel=%0d we=%b addr=%h be=%h wdata=%h lat=%0d", $time, name, sel, we, addr, be, wd, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (4) @(negedge clk);
    chk("reset_ready0", {31'b0, bus0.req_ready}, 32'd1);
    chk("reset_valid0", {31'b0, bus0.rsp_valid}, 32'd0);
    chk("reset_rdata0", bus0.rsp_rdata, 32'd0);
    chk("reset_err0", {31'b0, bus0.rsp_err}, 32'd0);
    chk("reset_ready3", {31'b0, bus3.req_ready}, 32'd1);
    chk("reset_valid3", {31'b0, bus3.rsp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    xact(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 0, "ld0_zero");
    xact(3, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 0, "ld3_zero");

    xact(0, 1'b1, 32'h4, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 0, "st_full");
    xact(0, 1'b0, 32'h4, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 0, "ld_full");
    xact(0, 1'b1, 32'h4, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0, 0, "st_byte1");
    xact(0, 1'b0, 32'h4, 4'h0, 32'h0, 32'h1234_AB78, 1'b0, 0, "ld_byte1");
    xact(0, 1'b0, 32'h7, 4'h0, 32'h0, 32'h1234_AB78, 1'b0, 0, "ld_lowbits");
    xact(0, 1'b1, 32'hFFC, 4'b1001, 32'hA5C3_3CA5, 32'h0, 1'b0, 0, "st_top");
    xact(0, 1'b0, 32'hFFC, 4'h0, 32'h0, 32'hA500_00A5, 1'b0, 0, "ld_top");

    xact(3, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 0, "st3");
    xact(3, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 1, "ld3_hold");

    xact(0, 1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 0, "ld_oor");
    xact(0, 1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, "st_be0");
    xact(0, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 0, "ld_after_be0");
    xact(0, 1'b1, 32'h8000_0008, 4'hF, 32'h5555_5555, 32'h0, 1'b1, 0, "st_oor");
    xact(0, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 0, "ld_after_oor");

    // Store aborted by reset while waiting: no response, nothing committed.
    drive(3, 1'b1, 1'b1, 32'hC, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(3, 1'b0, 1'b1, 32'hC, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", {31'b0, bus3.rsp_valid}, 32'd0);
    chk("abort_ready", {31'b0, bus3.req_ready}, 32'd1);
    $display("t=%0t reset asserted during dut3 store wait", $time);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xact(3, 1'b0, 32'hC, 4'h0, 32'h0, 32'h0, 1'b0, 0, "ld3_after_abort");
    xact(0, 1'b0, 32'h4, 4'h0, 32'h0, 32'h0, 1'b0, 0, "ld0_after_reset");

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
